// File: rtl/sterownik_wyswietlacza.sv
// Multiplexed driver for a 4-digit common-anode 7-segment clock display.
// Digits are snapshotted once per frame; set mode blinks the display, run mode blinks the colon.
module sterownik_wyswietlacza #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int BLINK_DIV = 25000000,
    parameter int LZ_BLANK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_jed,
    input  logic [3:0] min_dzie,
    input  logic [3:0] godz_jed,
    input  logic [3:0] godz_dzie,
    input  logic       start,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [3:0][3:0]   snap_q, snap_d;   // [0]=min_jed ... [3]=godz_dzie
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              scan_tick;
    logic              blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    assign scan_tick = (div_cnt_q == DIV_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_cnt_d   = div_cnt_q + 1'b1;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;

        if (scan_tick) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                snap_d = {godz_dzie, godz_jed, min_dzie, min_jed};
            end
        end

        if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        // Anti-ghosting gap, set-mode blink and hours-tens leading-zero suppression.
        blank = (div_cnt_q < BLANK_END)
             || (!start && phase_q)
             || ((LZ_BLANK != 0) && (idx_q == 2'd3) && (snap_q[3] == 4'd0));

        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = seg_decode(snap_q[idx_q]);
        dp_d  = ~((idx_q == 2'd2) && start && !phase_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            snap_q      <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
